// File: rtl/im_scan_ctrl.sv
// Raster-scan read controller for the image memory read port.
// On a start pulse it walks a rectangular window (base, width, height, stride),
// issues one read per pixel and streams the pixels out on a valid/ready
// interface tagged with end-of-line and end-of-frame markers.
// Ports:
//   clk, rst (async, active-low)
//   start, cfg_base, cfg_width, cfg_height, cfg_stride : scan request / window
//   busy, done                                         : scan status
//   im_r_en, im_r_addr, im_r_data                      : image memory read port
//   px_data, px_valid, px_ready, px_eol, px_last       : pixel stream
module im_scan_ctrl #(
    parameter int unsigned IM_ADDR_W = 16,
    parameter int unsigned IM_DATA_W = 8,
    parameter int unsigned DIM_W     = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [IM_ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]     cfg_width,
    input  logic [DIM_W-1:0]     cfg_height,
    input  logic [IM_ADDR_W-1:0] cfg_stride,
    output logic                 busy,
    output logic                 done,
    output logic                 im_r_en,
    output logic [IM_ADDR_W-1:0] im_r_addr,
    input  logic [IM_DATA_W-1:0] im_r_data,
    output logic [IM_DATA_W-1:0] px_data,
    output logic                 px_valid,
    input  logic                 px_ready,
    output logic                 px_eol,
    output logic                 px_last
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t               r_state;
    logic                 r_busy, r_done;
    logic [DIM_W-1:0]     r_w, r_h, r_x, r_y;
    logic [IM_ADDR_W-1:0] r_stride, r_line;
    logic                 r_issue_done;
    logic                 r_im_r_en;
    logic [IM_ADDR_W-1:0] r_im_r_addr;
    logic                 r_iss_eol, r_iss_last;
    logic                 r_arr, r_arr_eol, r_arr_last;
    logic [IM_DATA_W-1:0] r_fd [2];
    logic [1:0]           r_feol, r_flast;
    logic                 r_wp, r_rp;
    logic [1:0]           r_cnt;

    logic                 w_idle;
    logic [DIM_W-1:0]     w_w, w_h, w_x, w_y;
    logic [IM_ADDR_W-1:0] w_stride, w_line, w_addr;
    logic                 w_eol, w_lastpx, w_issue, w_credit_ok;
    logic                 w_fifo_ne, w_px_valid, w_pop, w_pop_fifo, w_push;
    logic [1:0]           w_cnt_n;
    logic [IM_DATA_W-1:0] w_head_data;
    logic                 w_head_eol, w_head_last, w_final;

    // Scan position: in IDLE the start cycle issues straight from cfg_* so the
    // first read lands in the cycle after start.
    always_comb begin
        w_idle   = (r_state == S_IDLE);
        w_w      = w_idle ? cfg_width  : r_w;
        w_h      = w_idle ? cfg_height : r_h;
        w_stride = w_idle ? cfg_stride : r_stride;
        w_line   = w_idle ? cfg_base   : r_line;
        w_x      = w_idle ? '0 : r_x;
        w_y      = w_idle ? '0 : r_y;
        w_addr   = IM_ADDR_W'(w_line + IM_ADDR_W'(w_x));
        w_eol    = (w_x == DIM_W'(w_w - DIM_W'(1)));
        w_lastpx = w_eol && (w_y == DIM_W'(w_h - DIM_W'(1)));
    end

    // Stream head: buffered entry first, otherwise bypass the arriving read data.
    always_comb begin
        w_fifo_ne   = (r_cnt != 2'd0);
        w_px_valid  = w_fifo_ne | r_arr;
        w_head_data = w_fifo_ne ? r_fd[r_rp]    : (r_arr ? im_r_data : '0);
        w_head_eol  = w_fifo_ne ? r_feol[r_rp]  : (r_arr & r_arr_eol);
        w_head_last = w_fifo_ne ? r_flast[r_rp] : (r_arr & r_arr_last);
        w_pop       = w_px_valid & px_ready;
        w_pop_fifo  = w_pop & w_fifo_ne;
        w_push      = r_arr & ~(w_pop & ~w_fifo_ne);
        w_cnt_n     = 2'(r_cnt + 2'(w_push) - 2'(w_pop_fifo));
        w_final     = w_pop & w_head_last;
        // Next cycle holds (buffered + arriving) pixels; a new read must still fit in 2.
        w_credit_ok = (3'(w_cnt_n) + 3'(r_im_r_en)) < 3'd2;
        w_issue     = w_idle ? (start && (w_w != '0) && (w_h != '0))
                             : ((r_state == S_SCAN) && !r_issue_done && w_credit_ok);
    end

    // FSM, read issue, and output buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_w          <= '0;
            r_h          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_stride     <= '0;
            r_line       <= '0;
            r_issue_done <= 1'b0;
            r_im_r_en    <= 1'b0;
            r_im_r_addr  <= '0;
            r_iss_eol    <= 1'b0;
            r_iss_last   <= 1'b0;
            r_arr        <= 1'b0;
            r_arr_eol    <= 1'b0;
            r_arr_last   <= 1'b0;
            for (int i = 0; i < 2; i++) r_fd[i] <= '0;
            r_feol       <= '0;
            r_flast      <= '0;
            r_wp         <= 1'b0;
            r_rp         <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_im_r_en <= w_issue;
            if (w_issue) begin
                r_im_r_addr  <= w_addr;
                r_iss_eol    <= w_eol;
                r_iss_last   <= w_lastpx;
                r_issue_done <= w_lastpx;
                if (w_eol) begin
                    r_x    <= '0;
                    r_y    <= DIM_W'(w_y + DIM_W'(1));
                    r_line <= IM_ADDR_W'(w_line + w_stride);
                end else begin
                    r_x    <= DIM_W'(w_x + DIM_W'(1));
                    r_y    <= w_y;
                    r_line <= w_line;
                end
            end

            // Read data returns one cycle after im_r_en, with the flags computed at issue.
            r_arr      <= r_im_r_en;
            r_arr_eol  <= r_iss_eol;
            r_arr_last <= r_iss_last;

            if (w_push) begin
                r_fd[r_wp]    <= im_r_data;
                r_feol[r_wp]  <= r_arr_eol;
                r_flast[r_wp] <= r_arr_last;
                r_wp          <= ~r_wp;
            end
            if (w_pop_fifo) r_rp <= ~r_rp;
            r_cnt <= w_cnt_n;

            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_w      <= cfg_width;
                        r_h      <= cfg_height;
                        r_stride <= cfg_stride;
                        if ((cfg_width == '0) || (cfg_height == '0)) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_final) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign im_r_en   = r_im_r_en;
    assign im_r_addr = r_im_r_addr;
    assign px_data   = w_head_data;
    assign px_valid  = w_px_valid;
    assign px_eol    = w_head_eol;
    assign px_last   = w_head_last;

endmodule

// File: tb/tb_im_scan_ctrl.sv
// Directed testbench for im_scan_ctrl with a synchronous image memory model.
module tb_im_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_base = '0;
    logic [9:0]  cfg_width = '0;
    logic [9:0]  cfg_height = '0;
    logic [15:0] cfg_stride = '0;
    logic        busy, done, im_r_en;
    logic [15:0] im_r_addr;
    logic [7:0]  im_r_data = '0;
    logic [7:0]  px_data;
    logic        px_valid, px_eol, px_last;
    logic        px_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    im_scan_ctrl #(.IM_ADDR_W(16), .IM_DATA_W(8), .DIM_W(10)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base(cfg_base), .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_stride(cfg_stride),
        .busy(busy), .done(done),
        .im_r_en(im_r_en), .im_r_addr(im_r_addr), .im_r_data(im_r_data),
        .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
        .px_eol(px_eol), .px_last(px_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] memf(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    always @(posedge clk) if (im_r_en) im_r_data <= memf(im_r_addr);

    // Observation record filled by monitor()
    logic [15:0] q_addr[$];
    logic [7:0]  q_data[$];
    logic        q_eol[$];
    logic        q_last[$];
    int          q_px_cyc[$];
    int          q_done_cyc[$];
    int          busy_cycles;
    int          stall_bad;
    int          max_out;

    task automatic clear_rec();
        q_addr.delete(); q_data.delete(); q_eol.delete(); q_last.delete();
        q_px_cyc.delete(); q_done_cyc.delete();
        busy_cycles = 0; stall_bad = 0; max_out = 0;
    endtask

    // Called on the negedge of cycle 0 with start raised; start is cleared in cycle 1.
    task automatic launch(input logic [15:0] b, input logic [9:0] w, input logic [9:0] h,
                          input logic [15:0] st);
        @(negedge clk);
        cfg_base = b; cfg_width = w; cfg_height = h; cfg_stride = st;
        start = 1'b1;
    endtask

    task automatic monitor(input int ncyc, input bit bp, input int s2,
                           input logic [15:0] b2, input logic [9:0] w2, input logic [9:0] h2);
        int issued = 0;
        int popped = 0;
        logic pv = 1'b0, pr = 1'b0, pe = 1'b0, pl = 1'b0;
        logic [7:0] pd = '0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == s2) begin
                start = 1'b1; cfg_base = b2; cfg_width = w2; cfg_height = h2; cfg_stride = 16'h0001;
            end
            px_ready = bp ? ((c + 1) % 3 == 0) : 1'b1;
            if (im_r_en) begin q_addr.push_back(im_r_addr); issued++; end
            if (issued - popped > max_out) max_out = issued - popped;
            if (busy) busy_cycles++;
            if (pv && !pr && (!px_valid || px_data !== pd || px_eol !== pe || px_last !== pl))
                stall_bad++;
            if (px_valid && px_ready) begin
                q_data.push_back(px_data); q_eol.push_back(px_eol);
                q_last.push_back(px_last); q_px_cyc.push_back(c); popped++;
            end
            if (done) q_done_cyc.push_back(c);
            pv = px_valid; pr = px_ready; pd = px_data; pe = px_eol; pl = px_last;
        end
        px_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, im_r_en, px_valid, px_eol, px_last} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 000000", {busy, done, im_r_en, px_valid, px_eol, px_last});
        end
        checks++;
        if (im_r_addr !== 16'h0 || px_data !== 8'h0) begin
            errors++; $display("FAIL reset_data got addr=%h data=%h want 0000/00", im_r_addr, px_data);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] ea [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                16'h0108, 16'h0109, 16'h010A, 16'h010B};
        clear_rec();
        launch(16'h0100, 10'd4, 10'd2, 16'h0008);
        monitor(16, 1'b0, 0, '0, '0, '0);
        checks++;
        if (q_addr.size() != 8 || q_data.size() != 8) begin
            errors++; $display("FAIL basic_count got reads=%0d px=%0d want 8/8", q_addr.size(), q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_addr.size() || q_addr[i] !== ea[i]) begin
                errors++; $display("FAIL basic_addr[%0d] got %h want %h", i, (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, ea[i]);
            end
            checks++;
            if (i >= q_data.size() || q_data[i] !== memf(ea[i]) || q_eol[i] !== (i == 3 || i == 7)
                || q_last[i] !== (i == 7) || q_px_cyc[i] != i + 2) begin
                errors++; $display("FAIL basic_px[%0d] got data/eol/last/cyc=%h/%b/%b/%0d want %h/%b/%b/%0d", i,
                    (i < q_data.size()) ? q_data[i] : 8'hxx, (i < q_data.size()) ? q_eol[i] : 1'bx,
                    (i < q_data.size()) ? q_last[i] : 1'bx, (i < q_data.size()) ? q_px_cyc[i] : -1,
                    memf(ea[i]), (i == 3 || i == 7), (i == 7), i + 2);
            end
        end
        checks++;
        if (q_done_cyc.size() != 1 || q_done_cyc[0] != 10) begin
            errors++; $display("FAIL basic_done got n=%0d cyc=%0d want 1 pulse at 10", q_done_cyc.size(),
                (q_done_cyc.size() > 0) ? q_done_cyc[0] : -1);
        end
        checks++;
        if (busy_cycles != 9) begin
            errors++; $display("FAIL basic_busy got %0d cycles want 9", busy_cycles);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] ea [8] = '{16'h0100, 16'h0101, 16'h0102, 16'h0103,
                                16'h0108, 16'h0109, 16'h010A, 16'h010B};
        clear_rec();
        launch(16'h0100, 10'd4, 10'd2, 16'h0008);
        monitor(40, 1'b1, 0, '0, '0, '0);
        checks++;
        if (q_data.size() != 8) begin
            errors++; $display("FAIL bp_count got %0d pixels want 8", q_data.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_data.size() || q_data[i] !== memf(ea[i]) || q_eol[i] !== (i == 3 || i == 7)
                || q_last[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_px[%0d] got %h want %h", i,
                    (i < q_data.size()) ? q_data[i] : 8'hxx, memf(ea[i]));
            end
        end
        checks++;
        if (stall_bad != 0) begin
            errors++; $display("FAIL bp_hold got %0d unstable stall cycles want 0", stall_bad);
        end
        checks++;
        if (max_out > 2) begin
            errors++; $display("FAIL bp_credit got max outstanding %0d want <=2", max_out);
        end
        checks++;
        if (q_done_cyc.size() != 1 || q_px_cyc.size() != 8 || q_done_cyc[0] != q_px_cyc[7] + 1) begin
            errors++; $display("FAIL bp_done got n=%0d want 1 pulse right after last pixel", q_done_cyc.size());
        end
    endtask

    task automatic test_zero_size();
        clear_rec();
        launch(16'h0040, 10'd0, 10'd5, 16'h0008);
        monitor(6, 1'b0, 0, '0, '0, '0);
        checks++;
        if (q_addr.size() != 0 || q_data.size() != 0) begin
            errors++; $display("FAIL zero_reads got reads=%0d px=%0d want 0/0", q_addr.size(), q_data.size());
        end
        checks++;
        if (q_done_cyc.size() != 1 || q_done_cyc[0] != 1) begin
            errors++; $display("FAIL zero_done got n=%0d want 1 pulse at cycle 1", q_done_cyc.size());
        end
        checks++;
        if (busy_cycles != 0) begin
            errors++; $display("FAIL zero_busy got %0d cycles want 0", busy_cycles);
        end
    endtask

    task automatic test_addr_wrap();
        logic [15:0] ea [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        clear_rec();
        launch(16'hFFFE, 10'd4, 10'd1, 16'h0100);
        monitor(10, 1'b0, 0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_addr.size() || q_addr[i] !== ea[i] || i >= q_data.size()
                || q_data[i] !== memf(ea[i]) || q_last[i] !== (i == 3)) begin
                errors++; $display("FAIL wrap[%0d] got addr=%h want %h", i,
                    (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, ea[i]);
            end
        end
        checks++;
        if (q_addr.size() != 4 || q_done_cyc.size() != 1) begin
            errors++; $display("FAIL wrap_count got reads=%0d done=%0d want 4/1", q_addr.size(), q_done_cyc.size());
        end
    endtask

    task automatic test_start_while_busy();
        logic [15:0] ea [8] = '{16'h0200, 16'h0201, 16'h0202, 16'h0203,
                                16'h0210, 16'h0211, 16'h0212, 16'h0213};
        clear_rec();
        launch(16'h0200, 10'd4, 10'd2, 16'h0010);
        monitor(20, 1'b0, 4, 16'h0300, 10'd2, 10'd1);
        checks++;
        if (q_addr.size() != 8) begin
            errors++; $display("FAIL s2_count got %0d reads want 8", q_addr.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= q_addr.size() || q_addr[i] !== ea[i]) begin
                errors++; $display("FAIL s2_addr[%0d] got %h want %h", i,
                    (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, ea[i]);
            end
        end
        checks++;
        if (q_done_cyc.size() != 1 || q_done_cyc[0] != 10) begin
            errors++; $display("FAIL s2_done got n=%0d want 1 pulse at 10", q_done_cyc.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] ea [4] = '{16'h0500, 16'h0501, 16'h0504, 16'h0505};
        launch(16'h0400, 10'd4, 10'd2, 16'h0008);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++;
        if (!(busy && px_valid && im_r_en)) begin
            errors++; $display("FAIL midrst_pre got busy/valid/en=%b%b%b want 111", busy, px_valid, im_r_en);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, im_r_en, px_valid, px_eol, px_last} !== 6'b0 || im_r_addr !== 16'h0 || px_data !== 8'h0) begin
            errors++; $display("FAIL midrst_out got ctrl=%b addr=%h data=%h want all zero",
                {busy, done, im_r_en, px_valid, px_eol, px_last}, im_r_addr, px_data);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_rec();
        launch(16'h0500, 10'd2, 10'd2, 16'h0004);
        monitor(12, 1'b0, 0, '0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= q_addr.size() || q_addr[i] !== ea[i] || i >= q_data.size()
                || q_data[i] !== memf(ea[i]) || q_eol[i] !== (i == 1 || i == 3)) begin
                errors++; $display("FAIL midrst_addr[%0d] got %h want %h", i,
                    (i < q_addr.size()) ? q_addr[i] : 16'hxxxx, ea[i]);
            end
        end
        checks++;
        if (q_data.size() != 4 || q_done_cyc.size() != 1 || q_done_cyc[0] != 6) begin
            errors++; $display("FAIL midrst_done got px=%0d done=%0d want 4 px, 1 pulse at 6",
                q_data.size(), q_done_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_size();
        test_addr_wrap();
        test_start_while_busy();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
